// File: rtl/firebird7_tdr_param.sv
// ---------------------------------------------------------------------------
// firebird7_tdr_param
//
// Parametrised IJTAG test data register for the firebird7 instrument network.
// Sits between the SIB/segment chain (ijtag_si / ijtag_so) and the instrument
// control/status pins.
//
// Build option:
//   FIREBIRD7_TDR_PARITY_EN  - when defined, the scan chain gains one parity
//                              bit (shifted in last), updates are applied only
//                              when the whole chain has even parity, and the
//                              ijtag_parity_err output is present.
//
// Parameters:
//   WIDTH         number of data bits (1..64)
//   RESET_VALUE   value of ijtag_data_out after reset
//   CAPTURE_MASK  1: capture live status (or sticky), 0: read back data_out
//   STICKY_MASK   1: bit is a sticky W1C status bit (must be in CAPTURE_MASK)
//
// Ports:
//   ijtag_tck         sole clock; posedge = capture/shift, negedge = update,
//                     sticky and scan-out retiming
//   ijtag_reset       synchronous active-high reset, sampled on both edges
//   ijtag_sel         register selected; qualifies ce/se/ue
//   ijtag_si          scan in
//   ijtag_ce          capture enable
//   ijtag_se          shift enable
//   ijtag_ue          update enable
//   ijtag_data_in     instrument status
//   ijtag_data_out    instrument control (update register)
//   ijtag_so          retimed scan out
//   ijtag_parity_err  last update rejected (parity build only)
// ---------------------------------------------------------------------------
module firebird7_tdr_param #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] CAPTURE_MASK = '0,
    parameter logic [WIDTH-1:0] STICKY_MASK  = '0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_si,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic [WIDTH-1:0] ijtag_data_in,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_so
`ifdef FIREBIRD7_TDR_PARITY_EN
    ,
    output logic             ijtag_parity_err
`endif
);

`ifdef FIREBIRD7_TDR_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int L = WIDTH + PAR_BITS;

    logic [L-1:0]     r_sr;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_sticky;
    logic             r_so;

    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_cap_data;
    logic [L-1:0]     w_cap_chain;
    logic [L-1:0]     w_shift_chain;
    logic             w_cap_en;
    logic             w_shift_en;
    logic             w_upd_req;
    logic             w_par_ok;
    logic             w_upd_ok;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_sticky_set;

    // Capture source: sticky bits report the latched flag, other capture
    // bits report the live status, the rest read back the update register.
    always_comb begin
        w_src      = (STICKY_MASK & r_sticky) | (~STICKY_MASK & ijtag_data_in);
        w_cap_data = (CAPTURE_MASK & w_src) | (~CAPTURE_MASK & r_data_out);
    end

`ifdef FIREBIRD7_TDR_PARITY_EN
    // Parity bit makes the captured chain even, so a straight shift-out and
    // shift-back is always accepted.
    assign w_cap_chain = {^w_cap_data, w_cap_data};
    assign w_par_ok    = ~(^r_sr);
`else
    assign w_cap_chain = w_cap_data;
    assign w_par_ok    = 1'b1;
`endif

    // Written as a loop so a one-bit chain needs no special casing.
    always_comb begin
        w_shift_chain = '0;
        for (int i = 0; i < L - 1; i++) begin
            w_shift_chain[i] = r_sr[i+1];
        end
        w_shift_chain[L-1] = ijtag_si;
    end

    assign w_cap_en     = ijtag_sel & ijtag_ce;
    assign w_shift_en   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign w_upd_req    = ijtag_sel & ijtag_ue;
    assign w_upd_ok     = w_upd_req & w_par_ok;
    assign w_w1c        = w_upd_ok ? (r_sr[WIDTH-1:0] & STICKY_MASK) : '0;
    assign w_sticky_set = ijtag_data_in & STICKY_MASK;

    // Shift/capture path.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_sr <= '0;
        end else if (w_cap_en) begin
            r_sr <= w_cap_chain;
        end else if (w_shift_en) begin
            r_sr <= w_shift_chain;
        end
    end

    // Update, sticky and retiming path. Sticky set is ORed in after the
    // clear so a status pulse coincident with a W1C is never lost.
    always_ff @(negedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_data_out <= RESET_VALUE;
            r_sticky   <= '0;
            r_so       <= 1'b0;
        end else begin
            r_so <= r_sr[0];
            if (w_upd_ok) begin
                r_data_out <= (r_data_out & STICKY_MASK) |
                              (r_sr[WIDTH-1:0] & ~STICKY_MASK);
            end
            r_sticky <= (r_sticky & ~w_w1c) | w_sticky_set;
        end
    end

`ifdef FIREBIRD7_TDR_PARITY_EN
    logic r_parity_err;

    always_ff @(negedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_parity_err <= 1'b0;
        end else if (w_upd_req) begin
            r_parity_err <= ~w_par_ok;
        end
    end

    assign ijtag_parity_err = r_parity_err;
`endif

    assign ijtag_data_out = r_data_out;
    assign ijtag_so       = r_so;

endmodule

// File: tb/tb_firebird7_tdr_param.sv
// ---------------------------------------------------------------------------
// tb_firebird7_tdr_param
//
// Self-checking bench for firebird7_tdr_param (WIDTH=8, RESET_VALUE=8'hA5,
// CAPTURE_MASK=8'h0F, STICKY_MASK=8'h03). Works in both the default and the
// FIREBIRD7_TDR_PARITY_EN builds. A queue-based reference model tracks the
// register; every clock step compares outputs against it, and directed
// sequences add constant expectations.
// ---------------------------------------------------------------------------
module tb_firebird7_tdr_param;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam logic [7:0] CM = 8'h0F;
    localparam logic [7:0] SM = 8'h03;
`ifdef FIREBIRD7_TDR_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = W + PB;

    logic       clk = 1'b0;
    logic       rst, sel, si, ce, se, ue;
    logic [7:0] din;
    logic [7:0] dout;
    logic       so;
`ifdef FIREBIRD7_TDR_PARITY_EN
    logic       perr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    firebird7_tdr_param #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .CAPTURE_MASK(CM),
        .STICKY_MASK (SM)
    ) dut (
        .ijtag_tck       (clk),
        .ijtag_reset     (rst),
        .ijtag_sel       (sel),
        .ijtag_si        (si),
        .ijtag_ce        (ce),
        .ijtag_se        (se),
        .ijtag_ue        (ue),
        .ijtag_data_in   (din),
        .ijtag_data_out  (dout),
        .ijtag_so        (so)
`ifdef FIREBIRD7_TDR_PARITY_EN
        ,
        .ijtag_parity_err(perr)
`endif
    );

    always #10 clk = ~clk;

    // Reference model: chain as a queue, element 0 leaves first.
    bit       m_q[$];
    bit [7:0] m_out;
    bit [7:0] m_sticky;
    bit       m_so;
    bit       m_perr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] chain(input logic [7:0] x);
        return (PB == 1) ? {^x, x} : {1'b0, x};
    endfunction

    task automatic model_negedge();
        bit       parity;
        bit [7:0] clr;
        clr = '0;
        if (rst) begin
            m_out = RV; m_sticky = '0; m_so = 0; m_perr = 0;
        end else begin
            m_so = m_q[0];
            if (sel && ue) begin
                parity = 0;
                foreach (m_q[k]) parity ^= m_q[k];
                if (PB == 1 && parity) begin
                    m_perr = 1;
                end else begin
                    m_perr = 0;
                    for (int i = 0; i < W; i++) begin
                        if (SM[i]) clr[i] = m_q[i];
                        else       m_out[i] = m_q[i];
                    end
                end
            end
            m_sticky = (m_sticky & ~clr) | (din & SM);
        end
    endtask

    task automatic model_posedge();
        bit [7:0] cap;
        if (rst) begin
            m_q = {};
            for (int i = 0; i < L; i++) m_q.push_back(1'b0);
        end else if (sel && ce) begin
            for (int i = 0; i < W; i++)
                cap[i] = CM[i] ? (SM[i] ? m_sticky[i] : din[i]) : m_out[i];
            m_q = {};
            for (int i = 0; i < W; i++) m_q.push_back(cap[i]);
            if (PB == 1) m_q.push_back(^cap);
        end else if (sel && se) begin
            void'(m_q.pop_front());
            m_q.push_back(si);
        end
    endtask

    // One clock: inputs applied mid-high, seen by the next negedge then the
    // next posedge; outputs compared 5 time units after that posedge.
    task automatic step(input bit r, input bit s, input bit c, input bit sh,
                        input bit u, input bit i, input logic [7:0] d);
        rst = r; sel = s; ce = c; se = sh; ue = u; si = i; din = d;
        @(negedge clk); model_negedge();
        @(posedge clk); model_posedge();
        #5;
        chk("dout", dout, m_out);
        chk("so", so, m_so);
`ifdef FIREBIRD7_TDR_PARITY_EN
        chk("perr", perr, m_perr);
`endif
    endtask

    task automatic shift_word(input logic [8:0] w, input int nbits, input logic [7:0] d);
        for (int k = 0; k < nbits; k++) step(0, 1, 0, 1, 0, w[k], d);
    endtask

    task automatic readout(input bit do_cap, input logic [8:0] exp, input string tag);
        logic [8:0] got;
        got = '0;
        if (do_cap) step(0, 1, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < L; k++) begin
            step(0, 1, 0, 1, 0, 0, 8'h00);
            got[k] = so;
        end
        chk(tag, got, exp);
    endtask

    task automatic update(input logic [7:0] d);
        step(0, 1, 0, 0, 1, 0, d);
    endtask

    initial begin
        for (int i = 0; i < L; i++) m_q.push_back(1'b0);
        rst = 1; sel = 0; ce = 0; se = 0; ue = 0; si = 0; din = 8'h00;
        @(posedge clk); #5;

        // Reset and reset-state capture
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("rst_dout", dout, 8'hA5);
        chk("rst_so", so, 1'b0);
        readout(1, chain(8'hA0), "rst_readout");

        // Shift/update: capture AC, shift 3C in while observing old contents
        step(0, 1, 1, 0, 0, 0, 8'h0C);
        begin
            logic [8:0] w, got;
            w = chain(8'h3C);
            got = '0;
            for (int k = 0; k < L; k++) begin
                step(0, 1, 0, 1, 0, w[k], 8'h00);
                got[k] = so;
            end
            chk("shift_old", got, chain(8'hAC));
        end
        update(8'h00);
        chk("upd_3c", dout, 8'h3D);

        // Sticky set, capture, W1C, and set-wins-over-clear
        step(0, 1, 0, 0, 0, 0, 8'h02);
        readout(1, chain(8'h32), "sticky_cap");
        shift_word(chain(8'h02), L, 8'h00);
        update(8'h00);
        chk("w1c_dout", dout, 8'h01);
        readout(1, chain(8'h00), "sticky_clr");
        step(0, 1, 0, 0, 0, 0, 8'h02);
        shift_word(chain(8'h02), L, 8'h00);
        update(8'h02);
        readout(1, chain(8'h02), "sticky_hold");

        // Capture beats shift; sel=0 blocks everything
        shift_word(chain(8'hFF), L, 8'h00);
        step(0, 1, 1, 1, 0, 0, 8'h00);
        readout(0, chain(8'h02), "cap_prio");
        shift_word(chain(8'hF0), L, 8'h00);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 1, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 1, 1, 1, 8'h00);
        chk("nosel_dout", dout, 8'h01);
        readout(0, chain(8'hF0), "nosel_sr");

`ifdef FIREBIRD7_TDR_PARITY_EN
        // Parity rejection and recovery
        shift_word(chain(8'hF0), L, 8'h00);
        update(8'h00);
        chk("par_good1", dout, 8'hF1);
        shift_word(9'h001, L, 8'h00);
        update(8'h00);
        chk("par_bad_dout", dout, 8'hF1);
        chk("par_bad_err", perr, 1'b1);
        shift_word(chain(8'h01), L, 8'h00);
        update(8'h00);
        chk("par_good_dout", dout, 8'h01);
        chk("par_good_err", perr, 1'b0);
`endif

        // Reset mid-shift, ue during reset
        shift_word(chain(8'h3C), 4, 8'h00);
        step(1, 1, 0, 0, 1, 0, 8'h00);
        step(1, 1, 0, 0, 1, 0, 8'h00);
        chk("midrst_dout", dout, 8'hA5);
        chk("midrst_so", so, 1'b0);
        readout(0, 9'h000, "midrst_sr");

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom),
                 8'($urandom & (($urandom_range(0, 1) == 1) ? 32'hFF : 32'h00)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
